// File: rtl/gray_counter_n_if.sv
// Control and status bundle for the Gray-code counter.
// The master drives the commands; the slave (the counter) returns the count and flags.
interface gray_counter_n_if #(
  parameter int WIDTH = 3
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadGray;
  logic             ClrFlag;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] Binary;
  logic             Overflow;
  logic             Underflow;
  logic             Wrap;

  modport master (
    output En,
    output Up,
    output Load,
    output LoadGray,
    output ClrFlag,
    input  Output,
    input  Binary,
    input  Overflow,
    input  Underflow,
    input  Wrap
  );

  modport slave (
    input  En,
    input  Up,
    input  Load,
    input  LoadGray,
    input  ClrFlag,
    output Output,
    output Binary,
    output Overflow,
    output Underflow,
    output Wrap
  );
endinterface

// File: rtl/gray_counter_n.sv
// Up/down counter with binary state and Gray-coded view.
// Wrapping or saturating ends, sticky overflow/underflow flags and a wrap pulse.
module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input logic             Clk,
  input logic             Reset,
  gray_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] load_bin;
  logic             ov_q;
  logic             ov_d;
  logic             un_q;
  logic             un_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             do_load;
  logic             do_inc;
  logic             do_dec;
  logic             at_max;
  logic             at_zero;

  // Bit i of the binary value is the xor of Gray bits WIDTH-1 down to i.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(bus.LoadGray >> i);
    end
  end

  assign do_load = bus.Load;
  assign do_inc  = !bus.Load && bus.En && bus.Up;
  assign do_dec  = !bus.Load && bus.En && !bus.Up;
  assign at_max  = (b_q == MAX);
  assign at_zero = (b_q == ZERO);

  // A set event in the same cycle overrides ClrFlag for that flag.
  always_comb begin
    b_d    = b_q;
    ov_d   = ov_q && !bus.ClrFlag;
    un_d   = un_q && !bus.ClrFlag;
    wrap_d = 1'b0;
    unique case (1'b1)
      do_load: begin
        b_d = load_bin;
      end
      do_inc && !at_max: begin
        b_d = b_q + ONE;
      end
      do_inc && at_max: begin
        ov_d   = 1'b1;
        wrap_d = 1'b1;
        b_d    = SATURATE ? MAX : ZERO;
      end
      do_dec && !at_zero: begin
        b_d = b_q - ONE;
      end
      do_dec && at_zero: begin
        un_d   = 1'b1;
        wrap_d = 1'b1;
        b_d    = SATURATE ? ZERO : MAX;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      b_q    <= '0;
      ov_q   <= 1'b0;
      un_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      ov_q   <= ov_d;
      un_q   <= un_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Output    = b_q ^ (b_q >> 1);
  assign bus.Binary    = b_q;
  assign bus.Overflow  = ov_q;
  assign bus.Underflow = un_q;
  assign bus.Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench: a wrapping 3-bit and a saturating 4-bit counter
// driven in lockstep and compared against an arithmetic reference model.
module tb_gray_counter_n;

  typedef struct {
    logic [15:0] g;
    logic [15:0] b;
    logic        ov;
    logic        un;
    logic        wr;
    bit          step;
  } exp_t;

  logic clk;
  logic rst;

  gray_counter_n_if #(.WIDTH(3)) bus3 ();
  gray_counter_n_if #(.WIDTH(4)) bus4 ();

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut3 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus3)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) dut4 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q3[$];
  exp_t q4[$];
  int   compared = 0;
  int   mismatched = 0;

  int wid[2] = '{3, 4};
  bit sat[2] = '{1'b0, 1'b1};
  int mb[2];
  bit mov[2];
  bit mun[2];
  bit mwr[2];

  function automatic int g2b(int g, int w);
    for (int v = 0; v < (1 << w); v++)
      if ((v ^ (v >> 1)) == g) return v;
    return 0;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(bit r, bit en, bit up, bit ld, bit clr, int lg3, int lg4);
    exp_t e;
    int   mx;
    int   lg;
    @(negedge clk);
    rst           = r;
    bus3.En       = en;
    bus3.Up       = up;
    bus3.Load     = ld;
    bus3.ClrFlag  = clr;
    bus3.LoadGray = lg3[2:0];
    bus4.En       = en;
    bus4.Up       = up;
    bus4.Load     = ld;
    bus4.ClrFlag  = clr;
    bus4.LoadGray = lg4[3:0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      mx = (1 << wid[k]) - 1;
      lg = (k == 0) ? lg3 : lg4;
      if (r) begin
        mb[k] = 0; mov[k] = 0; mun[k] = 0; mwr[k] = 0;
      end else begin
        mwr[k] = 0;
        if (clr) begin
          mov[k] = 0; mun[k] = 0;
        end
        if (ld) begin
          mb[k] = g2b(lg, wid[k]);
        end else if (en && up) begin
          if (mb[k] == mx) begin
            mov[k] = 1; mwr[k] = 1;
            mb[k] = sat[k] ? mx : 0;
          end else mb[k] = mb[k] + 1;
        end else if (en) begin
          if (mb[k] == 0) begin
            mun[k] = 1; mwr[k] = 1;
            mb[k] = sat[k] ? 0 : mx;
          end else mb[k] = mb[k] - 1;
        end
      end
      e.g    = 16'(mb[k] ^ (mb[k] >> 1));
      e.b    = 16'(mb[k]);
      e.ov   = mov[k];
      e.un   = mun[k];
      e.wr   = mwr[k];
      e.step = !r && !ld && en;
      if (k == 0) q3.push_back(e);
      else q4.push_back(e);
    end
  endtask

  logic [2:0] prev3;
  exp_t       m3;
  exp_t       m4;

  always @(negedge clk) begin
    while (q3.size() > 0) begin
      m3 = q3.pop_front();
      chk("w3 Output", 16'(bus3.Output), m3.g);
      chk("w3 Binary", 16'(bus3.Binary), m3.b);
      chk("w3 Overflow", 16'(bus3.Overflow), 16'(m3.ov));
      chk("w3 Underflow", 16'(bus3.Underflow), 16'(m3.un));
      chk("w3 Wrap", 16'(bus3.Wrap), 16'(m3.wr));
      if (m3.step)
        chk("w3 onebit", 16'($countones(prev3 ^ bus3.Output)), 16'd1);
      prev3 = bus3.Output;
    end
    while (q4.size() > 0) begin
      m4 = q4.pop_front();
      chk("w4 Output", 16'(bus4.Output), m4.g);
      chk("w4 Binary", 16'(bus4.Binary), m4.b);
      chk("w4 Overflow", 16'(bus4.Overflow), 16'(m4.ov));
      chk("w4 Underflow", 16'(bus4.Underflow), 16'(m4.un));
      chk("w4 Wrap", 16'(bus4.Wrap), 16'(m4.wr));
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus3.En = 0; bus3.Up = 0; bus3.Load = 0; bus3.ClrFlag = 0; bus3.LoadGray = '0;
    bus4.En = 0; bus4.Up = 0; bus4.Load = 0; bus4.ClrFlag = 0; bus4.LoadGray = '0;

    // Count up through a full cycle and across the wrap.
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Decrement from zero.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Load all-ones, then saturate/wrap upward.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3'b100, 4'b1000);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0);

    // Flag set wins over ClrFlag, then clears.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3'b100, 4'b1000);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3'b100, 4'b1000);
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);

    // Load overrides enable.
    step(0, 1, 1, 1, 0, 3'b110, 4'b0110);
    step(0, 1, 0, 1, 1, 3'b011, 4'b1011);

    // Reset mid-count with everything else asserted.
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 3'b111, 4'b1111);

    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)));
    end

    guard = 0;
    while ((q3.size() > 0 || q4.size() > 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    compared++;
    if (q3.size() != 0 || q4.size() != 0) begin
      mismatched++;
      $display("FAIL drain actual=%0d required=0", q3.size() + q4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
